malu_arbiter: RTL



---
 rtl/malu_pkg.sv | 12 +
 rtl/malu_core.sv | 15 +
 rtl/malu_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/malu_pkg.sv
// malu_pkg: shared opcodes and FSM state encoding for the malu arbiter and core
package malu_pkg;
  localparam logic [1:0] OP_AND     = 2'd0;
  localparam logic [1:0] OP_OR      = 2'd1;
  localparam logic [1:0] OP_XOR     = 2'd2;
  localparam logic [1:0] OP_ANDMASK = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/malu_core.sv
// malu_core: combinational four-operation logic unit shared by malu users
module malu_core
  import malu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] MASK = WIDTH'(4'b0110)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);
  // select the logic result for the opcode; ANDMASK flips the MASK bits of a&b
  always_comb y = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : (a & b) ^ MASK;
endmodule

// File: rtl/malu_arbiter.sv
// malu_arbiter: round-robin access to one malu_core with registered, ID-tagged responses
module malu_arbiter
  import malu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ = 2,
  parameter logic [WIDTH-1:0] MASK = WIDTH'(4'b0110),
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);
  state_t state, nxt;
  logic [IDW-1:0] rr_ptr, gnt, id_q, j;
  logic found, accept;
  logic [WIDTH-1:0] a_q, b_q, y;
  logic [1:0] op_q;
  malu_core #(.WIDTH(WIDTH), .MASK(MASK)) u_core (
    .a(a_q),
    .b(b_q),
    .op(op_q),
    .y(y)
  );
  // round-robin search starting just after the last winner; the nearest candidate is assigned last
  always_comb begin
    gnt = '0;
    found = 1'b0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[j]) begin
        found = 1'b1;
        gnt = j;
      end
    end
  end
  assign accept = state == S_IDLE && found;
  assign req_ready = accept && rst_n ? NREQ'(1) << gnt : '0;
  assign busy = state != S_IDLE;
  // next state: accept -> EXEC -> RESP -> IDLE on the response handshake; the spare code falls back to IDLE
  always_comb nxt = state == S_EXEC ? S_RESP : state == S_RESP ? (resp_ready ? S_IDLE : S_RESP) : accept ? S_EXEC : S_IDLE;
  // state register; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  end
  // capture the winner's operands, register the core result, clear valid on the response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      id_q <= '0;
      rr_ptr <= IDW'(NREQ - 1);
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_id <= '0;
    end else begin
      if (accept) begin
        a_q <= req_a[gnt*WIDTH +: WIDTH];
        b_q <= req_b[gnt*WIDTH +: WIDTH];
        op_q <= req_op[gnt*2 +: 2];
        id_q <= gnt;
        rr_ptr <= gnt;
      end
      if (state == S_EXEC) begin
        resp_data <= y;
        resp_id <= id_q;
        resp_valid <= 1'b1;
      end
      if (state == S_RESP && resp_ready) resp_valid <= 1'b0;
    end
  end
endmodule
